// File: rtl/win_accum_pkg.sv
// Shared types and width helpers for the windowed sample accumulator.
package win_accum_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    function automatic int cnt_width(input int win_len);
        return $clog2(win_len + 1);
    endfunction

    function automatic int sum_width(input int data_w, input int win_len);
        return data_w + $clog2(win_len + 1);
    endfunction

endpackage

// File: rtl/win_accum_if.sv
// Sample-in / result-out handshake bundle for win_accum.
interface win_accum_if #(
    parameter int DATA_W  = 8,
    parameter int WIN_LEN = 4
);
    import win_accum_pkg::*;

    localparam int SUM_W = sum_width(DATA_W, WIN_LEN);
    localparam int CNT_W = cnt_width(WIN_LEN);

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [SUM_W-1:0]  out_sum;
    logic [DATA_W-1:0] out_max;
    logic [DATA_W-1:0] out_min;
    logic [CNT_W-1:0]  out_cnt;

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_sum, out_max, out_min, out_cnt
    );

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_sum, out_max, out_min, out_cnt
    );

endinterface

// File: rtl/win_accum_minmax.sv
// Running max/min tracker; the outputs already include the sample presented this cycle.
module win_accum_minmax #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_i,
    input  logic              first_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] max_o,
    output logic [DATA_W-1:0] min_o
);

    logic [DATA_W-1:0] max_q;
    logic [DATA_W-1:0] min_q;

    always_comb begin
        max_o = max_q;
        min_o = min_q;
        if (sample_i) begin
            // First sample loads directly so nothing stale leaks into a new window.
            if (first_i) begin
                max_o = data_i;
                min_o = data_i;
            end else begin
                max_o = (data_i > max_q) ? data_i : max_q;
                min_o = (data_i < min_q) ? data_i : min_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_q <= '0;
            min_q <= '1;
        end else if (clear_i) begin
            max_q <= '0;
            min_q <= '1;
        end else if (sample_i) begin
            max_q <= max_o;
            min_q <= min_o;
        end
    end

endmodule

// File: rtl/win_accum.sv
// Groups a sample stream into windows and emits sum/max/min/count per window
// over a valid/ready result port that back-pressures the input.
module win_accum #(
    parameter int DATA_W  = 8,
    parameter int WIN_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    win_accum_if.slave bus
);
    import win_accum_pkg::*;

    localparam int SUM_W = sum_width(DATA_W, WIN_LEN);
    localparam int CNT_W = cnt_width(WIN_LEN);

    state_t            state_q, state_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [SUM_W-1:0]  out_sum_q, out_sum_d;
    logic [DATA_W-1:0] out_max_q, out_max_d;
    logic [DATA_W-1:0] out_min_q, out_min_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;

    logic              in_ready;
    logic              acc;
    logic              first;
    logic              close;
    logic [SUM_W-1:0]  tot_sum;
    logic [CNT_W-1:0]  tot_cnt;
    logic [DATA_W-1:0] tot_max;
    logic [DATA_W-1:0] tot_min;

    // In HOLD the input only moves when the result is being taken this cycle.
    assign in_ready = (state_q == ACCUM) | bus.out_ready;
    assign acc      = bus.in_valid & in_ready;
    assign first    = (cnt_q == '0);
    assign tot_cnt  = cnt_q + CNT_W'(acc);
    assign tot_sum  = !acc  ? sum_q :
                      first ? SUM_W'(bus.in_data) :
                              sum_q + SUM_W'(bus.in_data);
    // Accumulators are empty in HOLD, so one expression covers both states.
    assign close    = (acc && (tot_cnt == CNT_W'(WIN_LEN))) ||
                      (bus.flush && (tot_cnt != '0));

    win_accum_minmax #(
        .DATA_W (DATA_W)
    ) u_minmax (
        .clk      (clk),
        .rst      (rst),
        .sample_i (acc),
        .first_i  (first),
        .clear_i  (close),
        .data_i   (bus.in_data),
        .max_o    (tot_max),
        .min_o    (tot_min)
    );

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_max_d   = out_max_q;
        out_min_d   = out_min_q;
        out_cnt_d   = out_cnt_q;
        if (close) begin
            sum_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b1;
            out_sum_d   = tot_sum;
            out_max_d   = tot_max;
            out_min_d   = tot_min;
            out_cnt_d   = tot_cnt;
            state_d     = HOLD;
        end else begin
            if (acc) begin
                sum_d = tot_sum;
                cnt_d = tot_cnt;
            end
            if ((state_q == HOLD) && bus.out_ready) begin
                out_valid_d = 1'b0;
                state_d     = ACCUM;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCUM;
            sum_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_max_q   <= '0;
            out_min_q   <= '0;
            out_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_max_q   <= out_max_d;
            out_min_q   <= out_min_d;
            out_cnt_q   <= out_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_max   = out_max_q;
    assign bus.out_min   = out_min_q;
    assign bus.out_cnt   = out_cnt_q;

endmodule

// File: doc/win_accum.md
Name: win_accum

Overview:
Downstream consumer of the `m` datapath stage; takes its 8-bit `data_out` as a sample stream qualified by `in_valid`.
Groups samples into windows of WIN_LEN. For each window it emits sum, maximum, minimum and sample count over a valid/ready output handshake.
`flush` closes a partial window early. Backpressure on the output stalls the input through `in_ready`.

Parameters:
- DATA_W, 8, sample width; matches `m` `data_out`.
- WIN_LEN, 4, samples per window; must be ≥1.
- SUM_W (localparam), DATA_W+$clog2(WIN_LEN+1), accumulator width; never overflows.
- CNT_W (localparam), $clog2(WIN_LEN+1), count width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample present.
- in_data  in  DATA_W  unsigned sample.
- in_ready  out  1  block accepts sample this cycle.
- flush  in  1  close current partial window.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes result.
- out_sum  out  SUM_W  unsigned window sum.
- out_max  out  DATA_W  window maximum.
- out_min  out  DATA_W  window minimum.
- out_cnt  out  CNT_W  samples in window, 1..WIN_LEN.

Behaviour:
- Reset:
  - Asynchronous, immediate.
  - State=ACCUM; accumulator, count, max=0, min=all-ones.
  - out_valid=0; out_sum/out_max/out_min/out_cnt=0.
  - A partial window or pending result is discarded.
- Accept: `acc = in_valid & in_ready`. Unsigned arithmetic only.
- State ACCUM:
  - in_ready=1.
  - On acc: sum+=in_data, cnt+=1, max=max(max,in_data), min=min(min,in_data).
  - The first sample of a window loads sum/max/min directly; no stale data is carried over.
  - Window closes when acc brings cnt to WIN_LEN, or when flush=1 and (cnt>0 or acc).
  - On close:
    - Next cycle: out_valid=1, outputs = totals including the closing sample, state → HOLD.
    - Internal accumulators clear.
    - Latency: 1 cycle from the final accept to out_valid.
  - flush with cnt=0 and no acc is ignored; no zero-count result is ever emitted.
- State HOLD:
  - out_* stay stable while out_valid & ~out_ready.
  - in_ready = out_ready (pass-through: a sample accepted during the handshake cycle starts the next window).
  - On out_ready:
    - If that cycle's acc closes a window (WIN_LEN=1, or flush with acc), reload outputs and remain in HOLD with out_valid=1.
    - Otherwise out_valid=0 next cycle and state → ACCUM with cnt=acc?1:0.
  - flush in HOLD without acc is ignored.
- Simultaneous events:
  - flush and the WIN_LEN-th accept in the same cycle produce one result.
  - rst overrides everything.
- Throughput: with out_ready held 1, one sample per cycle sustained, no bubbles.
- in_data is sampled only on acc; X on in_data while in_valid=0 must not propagate.

Decomposition:
- Package win_accum_pkg:
  - state typedef enum logic {ACCUM, HOLD}.
  - SUM_W/CNT_W helper functions.
- One natural sub-module: win_accum_minmax.
  - Running max/min registers with load-first/update/clear controls.
  - Reused by later statistic stages.
- Sum/count/FSM stay in the top.

Test Plan:
1. WIN_LEN=4, out_ready=1, in_data 0x01,0x02,0x03,0x04 on consecutive cycles → one cycle later out_valid=1, out_sum=0x00A, out_max=0x04, out_min=0x01, out_cnt=4.
2. Four samples of 0xFF → out_sum=0x3FC (SUM_W=11 holds it without wrap), max=min=0xFF, cnt=4.
3. Backpressure: complete a window with out_ready=0 for 5 cycles → outputs frozen, in_ready=0, extra in_valid samples not consumed. Raise out_ready with in_data=0x07 valid → result retired and 0x07 counted as sample 1 of the next window.
4. Flush:
   - 0x10, 0x20 then flush=1 alone → out_sum=0x030, max=0x20, min=0x10, cnt=2.
   - flush with cnt=0 → no out_valid.
   - flush together with the 4th sample → exactly one result, cnt=4.
5. Reset mid-operation:
   - Assert rst asynchronously after 2 samples (between edges) → out_valid drops immediately.
   - A subsequent 1,1,1,1 gives out_sum=0x004 (old samples absent).
6. Sustained stream 0..11 with out_ready=1 → results 6, 22, 38 with cnt=4 and min/max (0,3),(4,7),(8,11); in_ready never deasserts.
